// File: rtl/hier_walk_sequencer_pkg.sv
// Shared types for the hierarchy walker.
// Contents:
//   hw_state_e - walker FSM states
//   null_id()  - all-ones "no node" index for a given node-index width
package hier_walk_pkg;

  typedef enum logic [2:0] {
    HW_IDLE       = 3'd0,
    HW_FETCH_ROOT = 3'd1,
    HW_CHECK      = 3'd2,
    HW_FETCH_NODE = 3'd3,
    HW_EMIT       = 3'd4,
    HW_DONE       = 3'd5
  } hw_state_e;

  // All-ones index of the given width; callers cast to their own width.
  function automatic logic [31:0] null_id(input int unsigned node_w);
    null_id = (32'd1 << node_w) - 32'd1;
  endfunction

endpackage

// File: rtl/hier_walk_sequencer_if.sv
// Bus bundle between the walker and its environment.
// Signals:
//   mem_req/mem_addr            walker -> node table read request
//   mem_ack/mem_first_child/
//   mem_next_sib                node table -> walker read response
//   visit_valid/visit_id/
//   visit_level                 walker -> consumer visit stream
//   visit_ready                 consumer -> walker acceptance
// Modports: master (walker side), slave (table + consumer side).
interface hier_walk_if #(
  parameter int NODE_W = 8,
  parameter int LVL_W  = 4
);
  logic              mem_req;
  logic [NODE_W-1:0] mem_addr;
  logic              mem_ack;
  logic [NODE_W-1:0] mem_first_child;
  logic [NODE_W-1:0] mem_next_sib;
  logic              visit_valid;
  logic              visit_ready;
  logic [NODE_W-1:0] visit_id;
  logic [LVL_W-1:0]  visit_level;

  modport master (
    output mem_req, mem_addr, visit_valid, visit_id, visit_level,
    input  mem_ack, mem_first_child, mem_next_sib, visit_ready
  );

  modport slave (
    input  mem_req, mem_addr, visit_valid, visit_id, visit_level,
    output mem_ack, mem_first_child, mem_next_sib, visit_ready
  );
endinterface

// File: rtl/hier_walk_sequencer_stack.sv
// LIFO of saved next-sibling pointers for the walker.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        synchronous clear (start of a new walk)
//   push, pop  never asserted together; push ignored when full, pop when empty
//   din        value pushed
//   top        most recently pushed value (0 when empty)
//   empty/full occupancy flags
module hier_walk_stack #(
  parameter int NODE_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [NODE_W-1:0] din,
  output logic [NODE_W-1:0] top,
  output logic              empty,
  output logic              full
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1'b1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  logic [NODE_W-1:0] mem_r [DEPTH];
  logic [SP_W-1:0]   sp_r;

  assign empty = (sp_r == {SP_W{1'b0}});
  assign full  = (sp_r == SP_FULL);

  // Stack pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r <= {SP_W{1'b0}};
    end else if (clr) begin
      sp_r <= {SP_W{1'b0}};
    end else if (push && !full) begin
      sp_r <= sp_r + SP_ONE;
    end else if (pop && !empty) begin
      sp_r <= sp_r - SP_ONE;
    end
  end

  // Entry storage; contents above sp are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[IDX_W'(sp_r)] <= din;
    end
  end

  // Top-of-stack read.
  always_comb begin
    if (!empty) begin
      top = mem_r[IDX_W'(sp_r - SP_ONE)];
    end else begin
      top = {NODE_W{1'b0}};
    end
  end
endmodule

// File: rtl/hier_walk_sequencer.sv
// Depth-first (pre-order) walker over a first_child/next_sibling node table.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start/root_id begin a walk of root_id's children (sampled in IDLE only)
//   busy          high from the cycle after start through DONE
//   done          one-cycle end-of-walk pulse
//   overflow      sticky: a descent was refused because the stack was full
//   cycle_err     sticky: visit limit (2^NODE_W-1) reached, table assumed looped
//   visit_count   visits emitted in the current/last walk
//   bus           table read port and visit stream (hier_walk_if.master)
module hier_walk_sequencer
  import hier_walk_pkg::*;
#(
  parameter int NODE_W    = 8,
  parameter int MAX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NODE_W-1:0] root_id,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              cycle_err,
  output logic [NODE_W:0]   visit_count,
  hier_walk_if.master       bus
);
  localparam int LVL_W = $clog2(MAX_DEPTH + 1);
  localparam logic [NODE_W-1:0] NULL_ID     = NODE_W'(null_id(NODE_W));
  localparam logic [NODE_W:0]   VISIT_LIMIT = (NODE_W + 1)'(null_id(NODE_W));
  localparam logic [NODE_W:0]   COUNT_ONE   = (NODE_W + 1)'(1'b1);
  localparam logic [LVL_W-1:0]  LVL_ONE     = LVL_W'(1'b1);

  hw_state_e         state_r;
  logic [NODE_W-1:0] cur_r;
  logic [NODE_W-1:0] fc_r;
  logic [NODE_W-1:0] ns_r;
  logic [LVL_W-1:0]  level_r;

  logic              push_s;
  logic              pop_s;
  logic              clr_s;
  logic [NODE_W-1:0] stk_top_s;
  logic              stk_empty_s;
  logic              stk_full_s;
  logic [NODE_W:0]   count_inc_s;
  logic              limit_hit_s;
  logic              fc_valid_s;

  hier_walk_stack #(
    .NODE_W (NODE_W),
    .DEPTH  (MAX_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (ns_r),
    .top   (stk_top_s),
    .empty (stk_empty_s),
    .full  (stk_full_s)
  );

  // Stack control and visit-limit detection derived from the current state.
  always_comb begin
    count_inc_s = visit_count + COUNT_ONE;
    limit_hit_s = (count_inc_s == VISIT_LIMIT);
    fc_valid_s  = (fc_r != NULL_ID);
    push_s      = 1'b0;
    pop_s       = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      HW_IDLE: begin
        if (start) begin
          clr_s = 1'b1;
        end else begin
          clr_s = 1'b0;
        end
      end
      HW_CHECK: begin
        if ((cur_r == NULL_ID) && !stk_empty_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      HW_EMIT: begin
        // The loop guard wins over descent: no push on the terminating visit.
        if (bus.visit_ready && !limit_hit_s && fc_valid_s && !stk_full_s) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Walker FSM; all outputs are registered and set on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= HW_IDLE;
      cur_r           <= '0;
      fc_r            <= '0;
      ns_r            <= '0;
      level_r         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      cycle_err       <= 1'b0;
      visit_count     <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.visit_valid <= 1'b0;
      bus.visit_id    <= '0;
      bus.visit_level <= '0;
    end else begin
      case (state_r)
        HW_IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            overflow     <= 1'b0;
            cycle_err    <= 1'b0;
            visit_count  <= '0;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= root_id;
            state_r      <= HW_FETCH_ROOT;
          end
        end
        HW_FETCH_ROOT: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            cur_r       <= bus.mem_first_child;
            level_r     <= '0;
            state_r     <= HW_CHECK;
          end
        end
        HW_CHECK: begin
          if (cur_r == NULL_ID) begin
            if (stk_empty_s) begin
              done    <= 1'b1;
              state_r <= HW_DONE;
            end else begin
              // Sibling list exhausted: resume at the saved sibling one level up.
              cur_r   <= stk_top_s;
              level_r <= level_r - LVL_ONE;
            end
          end else begin
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= cur_r;
            state_r      <= HW_FETCH_NODE;
          end
        end
        HW_FETCH_NODE: begin
          if (bus.mem_ack) begin
            bus.mem_req     <= 1'b0;
            fc_r            <= bus.mem_first_child;
            ns_r            <= bus.mem_next_sib;
            bus.visit_valid <= 1'b1;
            bus.visit_id    <= cur_r;
            bus.visit_level <= level_r;
            state_r         <= HW_EMIT;
          end
        end
        HW_EMIT: begin
          if (bus.visit_ready) begin
            bus.visit_valid <= 1'b0;
            visit_count     <= count_inc_s;
            if (limit_hit_s) begin
              cycle_err <= 1'b1;
              done      <= 1'b1;
              state_r   <= HW_DONE;
            end else begin
              if (fc_valid_s && !stk_full_s) begin
                level_r <= level_r + LVL_ONE;
                cur_r   <= fc_r;
              end else begin
                // Leaf, or a subtree that cannot be entered: move to the sibling.
                if (fc_valid_s) begin
                  overflow <= 1'b1;
                end
                cur_r <= ns_r;
              end
              state_r <= HW_CHECK;
            end
          end
        end
        HW_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= HW_IDLE;
        end
        default: begin
          state_r <= HW_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hier_walk_sequencer.sv
// Self-checking bench for hier_walk_sequencer (NODE_W=4, MAX_DEPTH=2).
// A node-table responder and a visit consumer run on the falling edge with
// programmable wait states; results are compared against hand-derived vectors
// and against a queue-based depth-first reference model on random tables.
module tb_hier_walk_sequencer;
  localparam int NW = 4;
  localparam int MD = 2;
  localparam int LW = 2;
  localparam logic [NW-1:0] NUL = 4'hF;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NW-1:0] root_id;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          cycle_err;
  logic [NW:0]   visit_count;

  hier_walk_if #(.NODE_W(NW), .LVL_W(LW)) bus ();

  hier_walk_sequencer #(.NODE_W(NW), .MAX_DEPTH(MD)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .root_id     (root_id),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .cycle_err   (cycle_err),
    .visit_count (visit_count),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [NW-1:0] fc_tab [16];
  logic [NW-1:0] ns_tab [16];
  int  ack_delay   = 0;
  int  ready_delay = 0;
  bit  ready_en    = 1'b1;
  int  addr_unstable = 0;
  int  vis_unstable  = 0;
  int  illegal       = 0;

  logic [NW-1:0] obs_id [$];
  logic [LW-1:0] obs_lv [$];
  logic [NW-1:0] exp_id [$];
  logic [LW-1:0] exp_lv [$];
  bit exp_ov;
  bit exp_ce;

  typedef struct {
    int            sel;
    logic [NW-1:0] root;
    int            ack_d;
    int            rdy_d;
    int            n;
    logic [15:0]   ids;   // first four expected ids, id0 in the low nibble
    logic [7:0]    lvs;   // first four expected levels, lvl0 in the low bits
    bit            ov;
    bit            ce;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Node table responder with ack_delay wait cycles per request.
  initial begin
    int mem_wait;
    logic [NW-1:0] held_addr;
    mem_wait = 0;
    held_addr = '0;
    bus.mem_ack = 1'b0;
    bus.mem_first_child = '0;
    bus.mem_next_sib = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !rst) begin
        if (mem_wait == 0) held_addr = bus.mem_addr;
        else if (bus.mem_addr !== held_addr) addr_unstable++;
        if (mem_wait >= ack_delay) begin
          bus.mem_ack = 1'b1;
          bus.mem_first_child = fc_tab[bus.mem_addr];
          bus.mem_next_sib = ns_tab[bus.mem_addr];
          mem_wait = 0;
        end else begin
          bus.mem_ack = 1'b0;
          mem_wait++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        mem_wait = 0;
      end
    end
  end

  // Visit consumer with ready_delay stall cycles; logs accepted visits.
  initial begin
    int vis_wait;
    logic [NW-1:0] hid;
    logic [LW-1:0] hlv;
    vis_wait = 0;
    hid = '0;
    hlv = '0;
    bus.visit_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && bus.visit_valid) illegal++;
      if (bus.visit_valid && !rst) begin
        if (vis_wait == 0) begin
          hid = bus.visit_id;
          hlv = bus.visit_level;
        end else if (bus.visit_id !== hid || bus.visit_level !== hlv) begin
          vis_unstable++;
        end
        if (ready_en && vis_wait >= ready_delay) begin
          bus.visit_ready = 1'b1;
          obs_id.push_back(bus.visit_id);
          obs_lv.push_back(bus.visit_level);
          vis_wait = 0;
        end else begin
          bus.visit_ready = 1'b0;
          vis_wait++;
        end
      end else begin
        bus.visit_ready = 1'b0;
        vis_wait = 0;
      end
    end
  end

  task automatic load_table(input int sel);
    for (int i = 0; i < 16; i++) begin
      fc_tab[i] = NUL;
      ns_tab[i] = NUL;
    end
    case (sel)
      0: begin fc_tab[0] = 4'd1; ns_tab[1] = 4'd2; ns_tab[2] = 4'd3; fc_tab[3] = 4'd4; end
      1: begin fc_tab[0] = 4'd1; fc_tab[1] = 4'd2; fc_tab[2] = 4'd3; fc_tab[3] = 4'd4; end
      2: begin fc_tab[0] = 4'd1; ns_tab[1] = 4'd1; end
      default: begin end
    endcase
  endtask

  // Reference: pre-order list of root's descendants, at most MD saved siblings,
  // stopping after 2^NW-1 visits.
  task automatic model(input logic [NW-1:0] r);
    logic [NW-1:0] stk [$];
    logic [NW-1:0] cur;
    int lvl;
    exp_id.delete();
    exp_lv.delete();
    exp_ov = 1'b0;
    exp_ce = 1'b0;
    cur = fc_tab[r];
    lvl = 0;
    while (1) begin
      while (cur == NUL && stk.size() > 0) begin
        cur = stk.pop_back();
        lvl--;
      end
      if (cur == NUL) break;
      exp_id.push_back(cur);
      exp_lv.push_back(LW'(lvl));
      if (exp_id.size() == 15) begin
        exp_ce = 1'b1;
        break;
      end
      if (fc_tab[cur] != NUL && stk.size() < MD) begin
        stk.push_back(ns_tab[cur]);
        lvl++;
        cur = fc_tab[cur];
      end else begin
        if (fc_tab[cur] != NUL) exp_ov = 1'b1;
        cur = ns_tab[cur];
      end
    end
  endtask

  // Start a walk from posedge+1 and wait (bounded) for done, then one more cycle.
  task automatic run_walk(input logic [NW-1:0] r, input string tag);
    int n;
    obs_id.delete();
    obs_lv.delete();
    addr_unstable = 0;
    vis_unstable = 0;
    start = 1'b1;
    root_id = r;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    if (done !== 1'b1) begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
    end else begin
      @(posedge clk); #1;
      check({tag, "_done_busy_after"}, {30'd0, done, busy}, 32'd0);
    end
  endtask

  task automatic compare_model(input string tag);
    int bad;
    bad = -1;
    check({tag, "_nvis"}, obs_id.size(), exp_id.size());
    for (int i = 0; i < exp_id.size(); i++) begin
      if (bad < 0) begin
        if (i >= obs_id.size()) bad = i;
        else if (obs_id[i] !== exp_id[i] || obs_lv[i] !== exp_lv[i]) bad = i;
      end
    end
    check({tag, "_seq_bad_idx"}, bad, -1);
    check({tag, "_count"}, 32'(visit_count), exp_id.size());
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ov));
    check({tag, "_cerr"}, 32'(cycle_err), 32'(exp_ce));
    check({tag, "_stable"}, addr_unstable + vis_unstable, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    root_id = '0;
    load_table(3);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, overflow, cycle_err, visit_count, bus.mem_req,
          bus.mem_addr, bus.visit_valid, bus.visit_id, bus.visit_level}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    vecs[0] = '{0, 4'd0, 0, 0, 4,  16'h4321, 8'h40, 1'b0, 1'b0};
    vecs[1] = '{0, 4'd0, 3, 5, 4,  16'h4321, 8'h40, 1'b0, 1'b0};
    vecs[2] = '{1, 4'd0, 0, 0, 3,  16'h0321, 8'h24, 1'b1, 1'b0};
    vecs[3] = '{0, 4'd3, 0, 1, 1,  16'h0004, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{2, 4'd0, 1, 0, 15, 16'h1111, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{0, 4'd1, 2, 0, 0,  16'h0000, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{3, 4'd0, 0, 0, 0,  16'h0000, 8'h00, 1'b0, 1'b0};

    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      load_table(vecs[v].sel);
      ack_delay = vecs[v].ack_d;
      ready_delay = vecs[v].rdy_d;
      run_walk(vecs[v].root, tag);
      check({tag, "_nvis"}, obs_id.size(), vecs[v].n);
      for (int i = 0; i < vecs[v].n && i < 4; i++) begin
        if (i < obs_id.size()) begin
          check($sformatf("%s_id%0d", tag, i), 32'(obs_id[i]), 32'(vecs[v].ids[4*i +: 4]));
          check($sformatf("%s_lvl%0d", tag, i), 32'(obs_lv[i]), 32'(vecs[v].lvs[2*i +: 2]));
        end
      end
      check({tag, "_count"}, 32'(visit_count), vecs[v].n);
      check({tag, "_ovf"}, 32'(overflow), 32'(vecs[v].ov));
      check({tag, "_cerr"}, 32'(cycle_err), 32'(vecs[v].ce));
      check({tag, "_stable"}, addr_unstable + vis_unstable, 32'd0);
    end

    // Empty root with zero-wait ack: done exactly three cycles after start.
    load_table(3);
    ack_delay = 0;
    ready_delay = 0;
    obs_id.delete();
    start = 1'b1;
    root_id = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("empty_busy_T%0d", c), 32'(busy), (c <= 3) ? 32'd1 : 32'd0);
      check($sformatf("empty_done_T%0d", c), 32'(done), (c == 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    check("empty_no_visit", obs_id.size(), 32'd0);

    // Reset while the second visit is being offered, then a clean rerun.
    load_table(0);
    ready_en = 1'b1;
    obs_id.delete();
    start = 1'b1;
    root_id = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (obs_id.size() < 1 && n < 200) begin @(posedge clk); #1; n++; end
    ready_en = 1'b0;
    n = 0;
    while (bus.visit_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    check("rst_reach_emit2", 32'(bus.visit_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midwalk_rst_outputs", 32'({busy, done, overflow, cycle_err, visit_count, bus.mem_req,
          bus.mem_addr, bus.visit_valid, bus.visit_id, bus.visit_level}), 32'd0);
    rst = 1'b0;
    ready_en = 1'b1;
    @(posedge clk); #1;
    run_walk(4'd0, "after_rst");
    model(4'd0);
    compare_model("after_rst");

    // Random tables, roots and wait states against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [NW-1:0] r;
      for (int i = 0; i < 16; i++) begin
        fc_tab[i] = ($urandom_range(0, 2) == 0) ? NW'($urandom_range(0, 14)) : NUL;
        ns_tab[i] = ($urandom_range(0, 1) == 0) ? NW'($urandom_range(0, 14)) : NUL;
      end
      r = NW'($urandom_range(0, 15));
      if (fc_tab[r] == NUL) fc_tab[r] = NW'($urandom_range(0, 14));
      ack_delay = $urandom_range(0, 2);
      ready_delay = $urandom_range(0, 2);
      run_walk(r, $sformatf("rnd%0d", t));
      model(r);
      compare_model($sformatf("rnd%0d", t));
    end

    check("req_and_valid_overlap", illegal, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
